instr_fetch_mem: RTL and testbench

Synchronous, parametrised instruction memory with a byte-wide program-load port and a valid/ready fetch interface for the IF stage of the 5-stage MIPS-32 pipeline. A supersede of the combinational byte-array instruction ROM: registered read (1-cycle latency), backpressure and flush from the pipeline, runtime program loading, and address checking with an error flag. Sits between the PC register and the IF/ID pipeline register.

---
 rtl/imem_pkg.sv | 17 +
 rtl/imem_byte_ram.sv | 66 ++++++
 rtl/instr_fetch_mem.sv | 139 +++++++++++++
 tb/tb_instr_fetch_mem.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction fetch memory.
// Holds the NOP constant, the load/run state encoding and the byte-parity helper.
package imem_pkg;

    localparam logic [31:0] IMEM_NOP_WORD = 32'h0000_0000;

    typedef enum logic {
        IMEM_LOAD = 1'b0,
        IMEM_RUN  = 1'b1
    } imem_state_e;

    // Even parity: the stored bit makes the total count of ones even.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/imem_byte_ram.sv
// Byte-wide RAM, one write port, four registered read ports at a..a+3 (1-cycle read, held when rd_en_i low).
// With IMEM_PARITY_EN defined a parity bit is stored and read back alongside each byte.
module imem_byte_ram #(
    parameter int DEPTH_BYTES = 4096,
    parameter int AW          = $clog2(DEPTH_BYTES)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [7:0]    wr_byte_i,
`ifdef IMEM_PARITY_EN
    input  logic          wr_par_i,
    output logic [3:0]    rd_par_o,
`endif
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [31:0]   rd_word_o
);

    logic [7:0]  mem_q [DEPTH_BYTES];
    logic [31:0] rd_word_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_byte_i;
        end
    end

    // Byte addresses wrap within AW bits, so every index stays inside the array.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rd_word_q <= '0;
        end else if (rd_en_i) begin
            for (int k = 0; k < 4; k++) begin
                rd_word_q[31-8*k -: 8] <= mem_q[rd_addr_i + AW'(k)];
            end
        end
    end

    assign rd_word_o = rd_word_q;

`ifdef IMEM_PARITY_EN
    logic       par_q [DEPTH_BYTES];
    logic [3:0] rd_par_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            par_q[wr_addr_i] <= wr_par_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rd_par_q <= '0;
        end else if (rd_en_i) begin
            for (int k = 0; k < 4; k++) begin
                rd_par_q[3-k] <= par_q[rd_addr_i + AW'(k)];
            end
        end
    end

    assign rd_par_o = rd_par_q;
`endif

endmodule

// File: rtl/instr_fetch_mem.sv
// IF-stage instruction memory: byte program load, then 1-cycle valid/ready fetch; response held while rsp_ready low.
// Define IMEM_PARITY_EN for per-byte parity storage/checking and the parity_inject port.
module instr_fetch_mem
    import imem_pkg::*;
#(
    parameter int          DEPTH_BYTES = 4096,
    parameter int          AW          = $clog2(DEPTH_BYTES),
    parameter logic [31:0] NOP_WORD    = IMEM_NOP_WORD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [7:0]  load_byte,
    input  logic        load_done,
`ifdef IMEM_PARITY_EN
    input  logic        parity_inject,
`endif
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_instr,
    output logic        rsp_err,
    input  logic        flush,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] DEPTH_32      = 32'(DEPTH_BYTES);
    localparam logic [31:0] LAST_WORD_ADR = 32'(DEPTH_BYTES - 4);

    imem_state_e state_q, state_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic        wr_en;
    logic        accept;
    logic        addr_err;
    logic        word_err;
    logic [31:0] rd_word;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IMEM_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        wr_en     = 1'b0;
        case (state_q)
            IMEM_LOAD: begin
                wr_en = load_en && (load_addr < DEPTH_32);
                if (load_done) begin
                    state_d = IMEM_RUN;
                end
            end
            IMEM_RUN: begin
                req_ready = ~rsp_valid_q | rsp_ready | flush;
            end
            default: state_d = IMEM_LOAD;
        endcase
    end

    assign accept   = req_valid & req_ready;
    assign addr_err = (req_addr[1:0] != 2'b00) || (req_addr > LAST_WORD_ADR);

    // A new accept always wins over the drop caused by rsp_ready or flush.
    always_comb begin
        rsp_valid_d   = rsp_valid_q;
        rsp_err_d     = rsp_err_q;
        fetch_count_d = fetch_count_q;
        if (accept) begin
            rsp_valid_d   = 1'b1;
            rsp_err_d     = addr_err;
            fetch_count_d = fetch_count_q + 32'd1;
        end else if (rsp_ready || flush) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            rsp_valid_q   <= rsp_valid_d;
            rsp_err_q     <= rsp_err_d;
            fetch_count_q <= fetch_count_d;
        end
    end

`ifdef IMEM_PARITY_EN
    logic [3:0] rd_par;
    logic       par_err;

    always_comb begin
        par_err = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (byte_parity(rd_word[31-8*k -: 8]) != rd_par[3-k]) begin
                par_err = 1'b1;
            end
        end
    end

    assign word_err = rsp_err_q | par_err;
`else
    assign word_err = rsp_err_q;
`endif

    imem_byte_ram #(
        .DEPTH_BYTES (DEPTH_BYTES),
        .AW          (AW)
    ) u_ram (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .wr_en_i   (wr_en),
        .wr_addr_i (load_addr[AW-1:0]),
        .wr_byte_i (load_byte),
`ifdef IMEM_PARITY_EN
        .wr_par_i  (byte_parity(load_byte) ^ parity_inject),
        .rd_par_o  (rd_par),
`endif
        .rd_en_i   (accept),
        .rd_addr_i (req_addr[AW-1:0]),
        .rd_word_o (rd_word)
    );

    assign rsp_valid   = rsp_valid_q;
    assign rsp_err     = word_err;
    assign rsp_instr   = word_err ? NOP_WORD : rd_word;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Bench for instr_fetch_mem: directed program/stall/flush/error cases plus randomized traffic against a reference model.
module tb_instr_fetch_mem;

    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_en = 1'b0;
    logic [31:0] load_addr = '0;
    logic [7:0]  load_byte = '0;
    logic        load_done = 1'b0;
    logic        parity_inject = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_instr;
    logic        rsp_err;
    logic        flush = 1'b0;
    logic [31:0] fetch_count;

    always #5 clk = ~clk;

    instr_fetch_mem #(.DEPTH_BYTES(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_byte   (load_byte),
        .load_done   (load_done),
`ifdef IMEM_PARITY_EN
        .parity_inject (parity_inject),
`endif
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_instr   (rsp_instr),
        .rsp_err     (rsp_err),
        .flush       (flush),
        .fetch_count (fetch_count)
    );

    int n_vec  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Reference model: byte array, loaded/running flag and the one outstanding response.
    bit [7:0]  mdl_mem [DEPTH];
    bit        mdl_bad [DEPTH];
    bit        m_run   = 1'b0;
    bit        m_valid = 1'b0;
    bit        m_err   = 1'b0;
    bit [31:0] m_instr = '0;
    bit [31:0] m_count = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit exp_ready();
        return m_run && (!m_valid || rsp_ready || flush);
    endfunction

    function automatic void mdl_fetch(input logic [31:0] a);
        if ((a % 4) != 0 || a > DEPTH - 4) begin
            m_err   = 1'b1;
            m_instr = 32'h0;
        end else begin
            m_err   = 1'b0;
            m_instr = {mdl_mem[a], mdl_mem[a+1], mdl_mem[a+2], mdl_mem[a+3]};
`ifdef IMEM_PARITY_EN
            if (mdl_bad[a] || mdl_bad[a+1] || mdl_bad[a+2] || mdl_bad[a+3]) begin
                m_err   = 1'b1;
                m_instr = 32'h0;
            end
`endif
        end
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_run   = 1'b0;
            m_valid = 1'b0;
            m_err   = 1'b0;
            m_instr = '0;
            m_count = '0;
        end else begin
            bit acc;
            acc = req_valid && exp_ready();
            if (!m_run) begin
                if (load_en && load_addr < DEPTH) begin
                    mdl_mem[load_addr] = load_byte;
                    mdl_bad[load_addr] = parity_inject;
                end
                if (load_done) m_run = 1'b1;
            end
            if (acc) begin
                mdl_fetch(req_addr);
                m_valid = 1'b1;
                m_count = m_count + 1;
            end else if (rsp_ready || flush) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", req_ready, exp_ready());
            chk("rsp_valid", rsp_valid, m_valid);
            chk("fetch_count", fetch_count, m_count);
            if (m_valid) begin
                chk("rsp_instr", rsp_instr, m_instr);
                chk("rsp_err", rsp_err, m_err);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] prog_byte(input int i);
        logic [31:0] w;
        w = $urandom;
        if (i < 4)                   w = 32'h012a5822;
        else if (i < 8)              w = 32'h012a6024;
        else if (i < 12)             w = 32'h012a6825;
        else if (i >= 168 && i < 172) w = 32'h012ab822;
        return w[31-8*(i%4) -: 8];
    endfunction

    task automatic rand_traffic(input int n);
        for (int c = 0; c < n; c++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_addr  = ($urandom_range(0, 15) == 0) ? $urandom : ($urandom_range(0, DEPTH/4 - 1) << 2);
            rsp_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 9) == 0);
            load_en   = ($urandom_range(0, 1) == 1);
            load_addr = 32'($urandom_range(0, DEPTH - 1));
            load_byte = 8'($urandom);
            load_done = ($urandom_range(0, 7) == 0);
            step();
        end
        flush     = 1'b0;
        load_en   = 1'b0;
        load_done = 1'b0;
    endtask

    initial begin
        step();
        step();
        chk_en = 1'b1;
        chk("reset req_ready", req_ready, 32'd0);
        chk("reset rsp_valid", rsp_valid, 32'd0);
        chk("reset rsp_instr", rsp_instr, 32'h0);
        chk("reset rsp_err", rsp_err, 32'd0);
        chk("reset fetch_count", fetch_count, 32'd0);
        rst_n = 1'b1;

        // Program load; fetch requests during LOAD must never be accepted.
        load_en = 1'b1;
        for (int i = 0; i < DEPTH - 1; i++) begin
            load_addr = i;
            load_byte = prog_byte(i);
            req_valid = ($urandom_range(0, 1) == 1);
            step();
        end
        req_valid = 1'b0;
        load_byte = 8'hEE;
        load_addr = 32'h1000; step();
        load_addr = 32'h1001; step();
        load_addr = 32'hFFFF_FFFC; step();
        load_addr = DEPTH - 1;
        load_byte = 8'h5A;
        load_done = 1'b1;
        step();
        load_en   = 1'b0;
        load_done = 1'b0;

        // First fetch the cycle after load_done, then back-to-back.
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        req_addr  = 0;
        step();
        chk("fetch0 instr", rsp_instr, 32'h012a5822);
        chk("fetch0 err", rsp_err, 32'd0);
        chk("fetch0 valid", rsp_valid, 32'd1);
        chk("fetch0 count", fetch_count, 32'd1);
        req_addr = 4; step();
        chk("fetch4 instr", rsp_instr, 32'h012a6024);
        req_addr = 8; step();
        chk("fetch8 instr", rsp_instr, 32'h012a6825);
        chk("b2b count", fetch_count, 32'd3);

        // Stall for three cycles, then release.
        req_addr = 0; step();
        rsp_ready = 1'b0;
        req_addr  = 4;
        for (int s = 0; s < 3; s++) begin
            step();
            chk("stall instr", rsp_instr, 32'h012a5822);
            chk("stall req_ready", req_ready, 32'd0);
            chk("stall count", fetch_count, 32'd4);
        end
        rsp_ready = 1'b1;
        step();
        chk("release instr", rsp_instr, 32'h012a6024);
        chk("release count", fetch_count, 32'd5);

        // Address errors and the last valid word.
        req_addr = 32'h2; step();
        chk("misalign err", rsp_err, 32'd1);
        chk("misalign instr", rsp_instr, 32'h0);
        req_addr = 32'h1000; step();
        chk("range err", rsp_err, 32'd1);
        chk("range instr", rsp_instr, 32'h0);
        req_addr = DEPTH - 4; step();
        chk("last word err", rsp_err, 32'd0);

        // Flush with redirect, then flush alone.
        req_addr = 0; step();
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        step();
        flush     = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'hA8;
        step();
        chk("redirect instr", rsp_instr, 32'h012ab822);
        chk("redirect valid", rsp_valid, 32'd1);
        req_valid = 1'b0;
        step();
        chk("flush drop valid", rsp_valid, 32'd0);
        flush     = 1'b0;
        rsp_ready = 1'b1;

        rand_traffic(3000);

        // Reset with a response pending; memory must survive.
        req_valid = 1'b1;
        req_addr  = 0;
        rsp_ready = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        chk("midreset valid", rsp_valid, 32'd0);
        chk("midreset count", fetch_count, 32'd0);
        chk("midreset req_ready", req_ready, 32'd0);
        rst_n = 1'b1;
        step();
        chk("load req_ready", req_ready, 32'd0);
`ifdef IMEM_PARITY_EN
        req_valid     = 1'b0;
        load_en       = 1'b1;
        load_addr     = 3;
        load_byte     = 8'h22;
        parity_inject = 1'b1;
        step();
        parity_inject = 1'b0;
        load_en       = 1'b0;
        load_done     = 1'b1;
        step();
        load_done = 1'b0;
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        req_addr  = 0;
        step();
        chk("parity err", rsp_err, 32'd1);
        chk("parity instr", rsp_instr, 32'h0);
        req_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n     = 1'b1;
        load_en   = 1'b1;
        load_addr = 3;
        load_byte = 8'h22;
        load_done = 1'b1;
        step();
        load_en   = 1'b0;
        load_done = 1'b0;
`else
        load_done = 1'b1;
        step();
        load_done = 1'b0;
`endif
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        req_addr  = 0;
        step();
        chk("survive instr", rsp_instr, 32'h012a5822);
        chk("survive count", fetch_count, 32'd1);

        rand_traffic(500);
        req_valid = 1'b0;
        step();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
